mux_2x1: RTL and testbench
==========================

// Module: mux_2x1
// PURPOSE
//   Two-input data selector with a registered output stage.
//   sel chooses din[0] (sel=0) or din[1] (sel=1).
//   The selection is driven out on a zero-latency combinational port and on a
//   one-cycle registered port.
//   Leaf datapath cell used wherever a clean, reset-defined 2:1 select is needed.
// PARAMETERS
//   DATA_W   1   width in bits of each data input lane and of each output
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous reset, active-low
//   sel        in   1          lane select: 0 -> lane 0, 1 -> lane 1
//   din        in   2*DATA_W   packed lanes; lane0=din[DATA_W-1:0], lane1=din[2*DATA_W-1:DATA_W]
//   in_valid   in   1          qualifies sel/din for the registered path
//   dout_comb  out  DATA_W     combinational select result, no latency
//   dout       out  DATA_W     registered select result, 1-cycle latency
//   out_valid  out  1          dout holds a value captured from a valid input
// BEHAVIOUR
//   - Clocking: one clock; reset is asynchronous and active-low (clk, rst_n).
//   - dout_comb = sel ? lane1 : lane0; purely combinational.
//     dout_comb follows input changes within the same delta; it is unaffected
//     by clk and by rst_n.
//   - sel X/Z: dout_comb equals lane0 when lane0==lane1, else X.
//     Synthesis is free to choose either lane.
//   - Reset (rst_n=0, asynchronous): dout=0, out_valid=0 immediately.
//     Both are held at 0 while rst_n is low.
//   - Release: flops update on the first rising clk edge after rst_n rises.
//   - On each rising clk edge with rst_n=1:
//       in_valid=1 -> dout <= dout_comb; out_valid <= 1
//       in_valid=0 -> dout holds its value; out_valid <= 0
//   - Latency: dout reflects the sel/din sampled at the previous edge; the
//     registered path is exactly 1 cycle.
//   - sel and din may change every cycle; there is no back-pressure.
//   - Reset asserted mid-stream discards the captured value; dout returns to 0.
//   - 1-bit truth table for dout_comb, listed as {sel,din[1],din[0]} -> out:
//       000->0  001->1  010->0  011->1  100->0  101->0  110->1  111->1
//   - Width rule: no arithmetic; each output bit is the selected lane's bit at
//     the same index.
// TESTING
//   1. Exhaustive sweep, DATA_W=1: step {sel,din} from 000 to 111, one per 5 units.
//      -> dout_comb matches the truth table above at every step.
//   2. Registered path: in_valid=1, sel=1, din=2'b10, one clk edge.
//      -> dout=1, out_valid=1; dout_comb=1 before the edge.
//   3. Hold: capture dout=1, then in_valid=0, sel=0, din=2'b00 for 3 edges.
//      -> dout stays 1; out_valid=0 from the first of those edges.
//   4. Async reset: while dout=1, drop rst_n between clk edges.
//      -> dout=0 and out_valid=0 before the next edge; they stay 0 until the
//         first edge after rst_n rises.
//   5. DATA_W=8: lane0=8'hA5, lane1=8'h3C; toggle sel every cycle with in_valid=1.
//      -> dout alternates A5/3C, one cycle behind sel; dout_comb has no lag.
//   6. Back-to-back: change sel/din every cycle for 16 random cycles, in_valid=1.
//      -> dout[n] equals dout_comb[n-1]; out_valid stays 1.

Source files
------------

// File: rtl/mux_2x1.sv
// ---------------------------------------------------------------------------
// mux_2x1
//   Two-input data selector with a combinational and a registered output.
//   sel picks lane 0 (sel=0) or lane 1 (sel=1) out of the packed din bus.
//   dout_comb is the select result with no latency. dout is the same result
//   registered once, and only when in_valid qualifies the inputs.
//
// Parameters
//   DATA_W     width in bits of each data lane and of each output
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous reset, active-low
//   sel        in   1          lane select: 0 -> lane 0, 1 -> lane 1
//   din        in   2*DATA_W   lane0 = din[DATA_W-1:0], lane1 = din[2*DATA_W-1:DATA_W]
//   in_valid   in   1          qualifies sel/din for the registered path
//   dout_comb  out  DATA_W     combinational select result
//   dout       out  DATA_W     registered select result, 1-cycle latency
//   out_valid  out  1          dout was captured from a valid input at the last edge
// ---------------------------------------------------------------------------
module mux_2x1 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic [2*DATA_W-1:0]   din,
  input  logic                  in_valid,
  output logic [DATA_W-1:0]     dout_comb,
  output logic [DATA_W-1:0]     dout,
  output logic                  out_valid
);

  // Bitwise lane select. The conditional operator is kept deliberately: with
  // an unknown sel it yields the lane value where both lanes agree and X
  // where they differ, which is the simulation behaviour we want to expose.
  function automatic logic [DATA_W-1:0] lane_select(
    input logic              s,
    input logic [DATA_W-1:0] lane0,
    input logic [DATA_W-1:0] lane1
  );
    return s ? lane1 : lane0;
  endfunction

  // ---- stage p0: combinational select --------------------------------------
  logic [DATA_W-1:0] lane0_p0;
  logic [DATA_W-1:0] lane1_p0;
  logic [DATA_W-1:0] sel_data_p0;
  logic              vld_p0;

  assign lane0_p0    = din[DATA_W-1:0];
  assign lane1_p0    = din[2*DATA_W-1:DATA_W];
  assign sel_data_p0 = lane_select(sel, lane0_p0, lane1_p0);
  assign vld_p0      = in_valid;

  assign dout_comb   = sel_data_p0;

  // ---- stage p1: registered output -----------------------------------------
  // The data register is reset as well so dout is defined (zero) out of reset
  // and any value captured before a mid-stream reset is discarded. It only
  // loads on a valid input; otherwise it holds while the valid flag drops.
  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        dout_p1 <= sel_data_p0;
      end
    end
  end

  assign dout      = dout_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_2x1.sv
// ---------------------------------------------------------------------------
// tb_mux_2x1
//   Directed bench for mux_2x1. Two instances share clock and reset: a 1-bit
//   instance for the truth table / registered / hold / reset scenarios and an
//   8-bit instance for the wide-lane and back-to-back scenarios.
// ---------------------------------------------------------------------------
module tb_mux_2x1;

  logic        clk;
  logic        rst_n;

  // 1-bit instance
  logic        sel1;
  logic [1:0]  din1;
  logic        in_valid1;
  logic [0:0]  dout_comb1;
  logic [0:0]  dout1;
  logic        out_valid1;

  // 8-bit instance
  logic        sel8;
  logic [15:0] din8;
  logic        in_valid8;
  logic [7:0]  dout_comb8;
  logic [7:0]  dout8;
  logic        out_valid8;

  int checks;
  int failures;

  mux_2x1 #(.DATA_W(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel1),
    .din       (din1),
    .in_valid  (in_valid1),
    .dout_comb (dout_comb1),
    .dout      (dout1),
    .out_valid (out_valid1)
  );

  mux_2x1 #(.DATA_W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel8),
    .din       (din8),
    .in_valid  (in_valid8),
    .dout_comb (dout_comb8),
    .dout      (dout8),
    .out_valid (out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    sel1 = 1'b0; din1 = 2'b00; in_valid1 = 1'b0;
    sel8 = 1'b0; din8 = 16'h0000; in_valid8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dout1 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w1: dout=%b out_valid=%b, required 0/0", dout1, out_valid1);
    end
    checks++;
    if (dout8 !== 8'h00 || out_valid8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w8: dout=%h out_valid=%b, required 00/0", dout8, out_valid8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [7:0] tt;
    logic [2:0] v;
    tt = 8'b1100_1010;  // out for {sel,din[1],din[0]} = 7..0
    in_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {sel1, din1} = v;
      #5;
      checks++;
      if (dout_comb1 !== tt[v]) begin
        failures++;
        $display("FAIL truth_table[%0d]: dout_comb=%b, required %b", i, dout_comb1, tt[v]);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    in_valid1 = 1'b1; sel1 = 1'b1; din1 = 2'b10;
    #1;
    checks++;
    if (dout_comb1 !== 1'b1) begin
      failures++;
      $display("FAIL registered_comb: dout_comb=%b, required 1", dout_comb1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout1 !== 1'b1 || out_valid1 !== 1'b1) begin
      failures++;
      $display("FAIL registered_out: dout=%b out_valid=%b, required 1/1", dout1, out_valid1);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    in_valid1 = 1'b0; sel1 = 1'b0; din1 = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (dout1 !== 1'b1 || out_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: dout=%b out_valid=%b, required 1/0", k, dout1, out_valid1);
      end
    end
  endtask

  task automatic test_async_reset();
    // Re-capture a 1 so the reset has something to discard.
    @(negedge clk);
    in_valid1 = 1'b1; sel1 = 1'b1; din1 = 2'b10;
    @(posedge clk);
    #1;
    checks++;
    if (dout1 !== 1'b1) begin
      failures++;
      $display("FAIL async_precond: dout=%b, required 1", dout1);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout1 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL async_assert: dout=%b out_valid=%b, required 0/0", dout1, out_valid1);
    end
    checks++;
    if (dout_comb1 !== 1'b1) begin
      failures++;
      $display("FAIL async_comb: dout_comb=%b, required 1", dout_comb1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout1 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL async_held: dout=%b out_valid=%b, required 0/0", dout1, out_valid1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dout1 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL async_release: dout=%b out_valid=%b, required 0/0", dout1, out_valid1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout1 !== 1'b1 || out_valid1 !== 1'b1) begin
      failures++;
      $display("FAIL async_first_edge: dout=%b out_valid=%b, required 1/1", dout1, out_valid1);
    end
  endtask

  task automatic test_width8();
    logic [7:0] exp_now;
    logic [7:0] exp_prev;
    exp_prev = 8'h00;
    in_valid8 = 1'b1;
    din8 = {8'h3C, 8'hA5};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sel8 = k[0];
      exp_now = k[0] ? 8'h3C : 8'hA5;
      #1;
      checks++;
      if (dout_comb8 !== exp_now) begin
        failures++;
        $display("FAIL w8_comb[%0d]: dout_comb=%h, required %h", k, dout_comb8, exp_now);
      end
      checks++;
      if (dout8 !== exp_prev) begin
        failures++;
        $display("FAIL w8_lag[%0d]: dout=%h, required %h", k, dout8, exp_prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dout8 !== exp_now || out_valid8 !== 1'b1) begin
        failures++;
        $display("FAIL w8_reg[%0d]: dout=%h out_valid=%b, required %h/1", k, dout8, out_valid8, exp_now);
      end
      exp_prev = exp_now;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_now;
    logic [7:0] exp_prev;
    logic [7:0] comb_prev;
    in_valid8 = 1'b1;
    exp_prev  = dout8 === 8'h3C ? 8'h3C : 8'hA5;  // last value left by test_width8
    exp_prev  = 8'h3C;
    comb_prev = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      sel8 = 1'($urandom_range(0, 1));
      din8 = 16'($urandom_range(0, 65535));
      exp_now = sel8 ? din8[15:8] : din8[7:0];
      #1;
      checks++;
      if (dout_comb8 !== exp_now) begin
        failures++;
        $display("FAIL b2b_comb[%0d]: dout_comb=%h, required %h", k, dout_comb8, exp_now);
      end
      checks++;
      if (dout8 !== comb_prev) begin
        failures++;
        $display("FAIL b2b_lag[%0d]: dout=%h, required %h", k, dout8, comb_prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dout8 !== exp_now || out_valid8 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_reg[%0d]: dout=%h out_valid=%b, required %h/1", k, dout8, out_valid8, exp_now);
      end
      comb_prev = exp_now;
      exp_prev  = exp_now;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_truth_table();
    test_registered();
    test_hold();
    test_async_reset();
    test_width8();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
